// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - round-robin arbiter sharing one single-beat AXI4 master port among N clients
module axi_mem_arbiter #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  input  logic [N*4-1:0]  req_wstrb,
  input  logic [N*3-1:0]  req_size,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            awvalid,
  input  logic            awready,
  output logic [AW-1:0]   awaddr,
  output logic [2:0]      awsize,
  output logic            wvalid,
  input  logic            wready,
  output logic [DW-1:0]   wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  output logic            arvalid,
  input  logic            arready,
  output logic [AW-1:0]   araddr,
  output logic [2:0]      arsize,
  input  logic            rvalid,
  output logic            rready,
  input  logic [DW-1:0]   rdata,
  input  logic [1:0]      rresp
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_t;

  state_t        state, state_next;
  logic [IW-1:0] rr_ptr, idx_q, gnt_idx;
  logic          gnt_found;
  int            arb_j;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wstrb_q;
  logic [2:0]    size_q;
  logic          aw_done, w_done;
  logic          accept, aw_hs, w_hs, rd_done, wr_done;

  // First requester at or after rr_ptr, wrapping past N-1.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    arb_j     = 0;
    for (int k = 0; k < N; k++) begin
      arb_j = int'(rr_ptr) + k;
      if (arb_j >= N) arb_j = arb_j - N;
      if (!gnt_found && req_valid[arb_j[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_j[IW-1:0];
      end
    end
  end

  // Handshake outputs are masked during reset so a mid-transaction reset cannot leak a pulse.
  always_comb begin
    accept  = (state == IDLE) && gnt_found && !reset;
    arvalid = (state == RD_A) && !reset;
    rready  = (state == RD_D) && !reset;
    awvalid = (state == WR_AW) && !aw_done && !reset;
    wvalid  = (state == WR_AW) && !w_done && !reset;
    bready  = (state == WR_B) && !reset;
    wlast   = wvalid;
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    rd_done = rready && rvalid;
    wr_done = bready && bvalid;

    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;

    rsp_valid = '0;
    if (rd_done || wr_done) rsp_valid[idx_q] = 1'b1;
    rsp_rdata = rd_done ? rdata : '0;
    rsp_err   = rd_done ? (|rresp) : (wr_done ? (|bresp) : 1'b0);

    araddr = addr_q;
    awaddr = addr_q;
    arsize = size_q;
    awsize = size_q;
    wdata  = wdata_q;
    wstrb  = wstrb_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = req_write[gnt_idx] ? WR_AW : RD_A;
      RD_A:  if (arvalid && arready) state_next = RD_D;
      RD_D:  if (rd_done) state_next = IDLE;
      WR_AW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_B;
      WR_B:  if (wr_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx_q   <= gnt_idx;
        addr_q  <= req_addr[gnt_idx*AW +: AW];
        wdata_q <= req_wdata[gnt_idx*DW +: DW];
        wstrb_q <= req_wstrb[gnt_idx*4 +: 4];
        size_q  <= req_size[gnt_idx*3 +: 3];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WR_AW) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end
      if (rd_done || wr_done)
        rr_ptr <= (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    end
  end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed and randomized bench for axi_mem_arbiter against a transaction-level model
module tb_axi_mem_arbiter;
  localparam int N = 2, AW = 32, DW = 32;

  logic            clock, reset;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [N*3-1:0]  req_size;
  logic [DW-1:0]   rsp_rdata, wdata, rdata;
  logic            rsp_err;
  logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awsize, arsize;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;

  int checks = 0;
  int errors = 0;
  int ptr = 0;
  int last_g = 0;

  axi_mem_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference arbitration: first set bit of mask scanning from p with wrap.
  function automatic int pick(input int p, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int c, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] z);
    req_valid[c]         = v;
    req_write[c]         = w;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
    req_wstrb[c*4 +: 4]  = s;
    req_size[c*3 +: 3]   = z;
  endtask

  // One whole transaction; ad/wd = cycles before AW/AR and W ready, rd = cycles before R/B valid.
  task automatic txn(input int ad, input int wd, input int rd, input logic [1:0] resp,
                     input logic [31:0] rdat, input bit scramble);
    int g;
    logic w;
    logic [31:0] a, d;
    logic [3:0] s;
    logic [2:0] z;
    logic [N-1:0] oh;
    g  = pick(ptr, req_valid);
    if (g < 0) g = 0;
    oh = N'(1) << g;
    w = req_write[g];
    a = req_addr[g*AW +: AW];
    d = req_wdata[g*DW +: DW];
    s = req_wstrb[g*4 +: 4];
    z = req_size[g*3 +: 3];
    #1;
    chk("grant", req_ready, oh);
    last_g = g;
    tick();
    if (!w) begin
      for (int c = 0; c <= ad; c++) begin
        arready = (c == ad);
        if (scramble) req_addr = {$urandom, $urandom};
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arsize", arsize, z);
        chk("busy_req_ready", req_ready, 0);
        tick();
      end
      arready = 1'b0;
      for (int c = 0; c <= rd; c++) begin
        rvalid = (c == rd);
        rdata  = (c == rd) ? rdat : $urandom;
        rresp  = (c == rd) ? resp : 2'($urandom_range(0, 3));
        #1;
        chk("rready", rready, 1);
        chk("rsp_valid_rd", rsp_valid, (c == rd) ? oh : '0);
        if (c == rd) begin
          chk("rsp_rdata", rsp_rdata, rdat);
          chk("rsp_err_rd", rsp_err, |resp);
        end
        tick();
      end
      rvalid = 1'b0;
    end else begin
      for (int c = 0; c <= ((ad > wd) ? ad : wd); c++) begin
        awready = (c >= ad);
        wready  = (c >= wd);
        #1;
        chk("awvalid", awvalid, c <= ad);
        chk("wvalid", wvalid, c <= wd);
        chk("wlast", wlast, c <= wd);
        chk("busy_req_ready", req_ready, 0);
        if (c <= ad) begin
          chk("awaddr", awaddr, a);
          chk("awsize", awsize, z);
        end
        if (c <= wd) begin
          chk("wdata", wdata, d);
          chk("wstrb", wstrb, s);
        end
        tick();
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int c = 0; c <= rd; c++) begin
        bvalid = (c == rd);
        bresp  = (c == rd) ? resp : 2'($urandom_range(0, 3));
        #1;
        chk("bready", bready, 1);
        chk("awvalid_in_b", awvalid, 0);
        chk("rsp_valid_wr", rsp_valid, (c == rd) ? oh : '0);
        if (c == rd) begin
          chk("rsp_err_wr", rsp_err, |resp);
          chk("rsp_rdata_wr", rsp_rdata, 0);
        end
        tick();
      end
      bvalid = 1'b0;
    end
    ptr = (g + 1) % N;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_size = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_quiet("reset");
    chk("reset_req_ready", req_ready, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_wstrb", wstrb, 0);

    // No requesters: stay idle.
    tick();
    #1;
    chk("idle_req_ready", req_ready, 0);
    chk_quiet("idle");

    // Single read from client 0 with arready after two waits.
    set_req(0, 1, 0, 32'h8000_0000, 32'h0, 4'h0, 3'd2);
    txn(2, 0, 0, 2'b00, 32'h0000_0413, 0);
    set_req(0, 0, 0, 0, 0, 0, 0);

    // Reset while in RD_D with rvalid high: no response, then grant restarts at client 0.
    set_req(1, 1, 0, 32'h8000_0200, 32'h0, 4'h0, 3'd2);
    #1;
    chk("rst_grant1", req_ready, 2'b10);
    tick();
    arready = 1'b1;
    #1;
    chk("rst_arvalid", arvalid, 1);
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h1234_5678;
    reset = 1'b1;
    #1;
    chk("rst_no_rsp", rsp_valid, 0);
    tick();
    reset = 1'b0;
    rvalid = 1'b0;
    req_valid = '0;
    #1;
    chk_quiet("post_rst");
    chk("post_rst_req_ready", req_ready, 0);
    chk("post_rst_araddr", araddr, 0);
    ptr = 0;
    tick();
    set_req(0, 1, 0, 32'h8000_0010, 0, 0, 3'd2);
    set_req(1, 1, 0, 32'h8000_0020, 0, 0, 3'd2);
    txn(0, 0, 1, 2'b00, 32'hCAFE_0001, 0);
    chk("post_rst_first_grant", last_g, 0);
    req_valid = '0;

    // Write from client 1: W accepted at once, AW after three waits, SLVERR.
    set_req(1, 1, 1, 32'h8000_0104, 32'hDEAD_BEEF, 4'hF, 3'd2);
    txn(3, 0, 0, 2'b10, 32'h0, 0);
    req_valid = '0;

    // Contention with a zero-wait slave.
    ptr = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 1'(i % 2), 32'h1000_0000 + i, 32'hA000_0000 + i, 4'h3, 3'd1);
      set_req(1, 1, 1'((i + 1) % 2), 32'h2000_0000 + i, 32'hB000_0000 + i, 4'hC, 3'd1);
      txn(0, 0, 0, 2'b00, 32'h5500_0000 + i, 0);
      chk("contention_order", last_g, i % 2);
    end
    req_valid = '0;

    // Simultaneous AW/W handshake.
    set_req(0, 1, 1, 32'h8000_0300, 32'h0BAD_F00D, 4'h5, 3'd2);
    txn(0, 0, 0, 2'b00, 32'h0, 0);
    req_valid = '0;

    // Address stability while client 1 keeps changing its request.
    set_req(1, 1, 0, 32'h8000_0400, 0, 0, 3'd2);
    req_valid[0] = 1'b0;
    ptr = pick(ptr, 2'b10) == 1 ? ptr : ptr;
    txn(10, 0, 0, 2'b01, 32'h7777_7777, 1);
    req_valid = '0;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      for (int c = 0; c < N; c++)
        set_req(c, mask[c], 1'($urandom_range(0, 1)), $urandom, $urandom,
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 2)));
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          2'($urandom_range(0, 3)), $urandom, 0);
    end
    req_valid = '0;
    #1;
    chk("final_idle_req_ready", req_ready, 0);
    chk_quiet("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Shares the single AXI4 master port of the core between N simple request/response clients: client 0 = IFU fetch, client 1 = LSU load/store.
- Issues single-beat transactions only, with at most one outstanding transaction on the port.
- Round-robin arbitration between clients.
- The top-level wrapper drives the constant tie-offs: id = 0, len = 0, burst = INCR.

Parameters:
N, 2, number of requesters (index 0 highest priority after reset)
AW, 32, address width
DW, 32, data width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  N  per-client request valid
req_ready  out  N  per-client request accept
req_write  in  N  1 = write, 0 = read
req_addr  in  N*AW  packed request addresses, client i at [i*AW +: AW]
req_wdata  in  N*DW  packed write data
req_wstrb  in  N*4  packed write strobes
req_size  in  N*3  packed AXI size codes
rsp_valid  out  N  one-cycle completion pulse to the owning client
rsp_rdata  out  DW  read data, raw bus lanes, valid with rsp_valid
rsp_err  out  1  1 when rresp/bresp != 0, valid with rsp_valid
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
awaddr  out  AW  AXI AW address
awsize  out  3  AXI AW size
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
wdata  out  DW  AXI W data
wstrb  out  4  AXI W strobe
wlast  out  1  AXI W last, equal to wvalid
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
bresp  in  2  AXI B response
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  AW  AXI AR address
arsize  out  3  AXI AR size
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  DW  AXI R data
rresp  in  2  AXI R response

Behaviour:
- States: IDLE, RD_A, RD_D, WR_AW, WR_B.
- Reset forces:
  - State to IDLE and rr_ptr to 0.
  - All valid/ready outputs and rsp_* to 0.
  - Address, data, size and strobe registers to 0.
- Arbitration in IDLE:
  - The grant is the first client with req_valid set, searching from rr_ptr upward with wrap at N-1→0.
  - req_ready is combinational: it equals the grant one-hot when state is IDLE, otherwise 0.
  - On req_valid & req_ready, latch the client index, write, addr, wdata, wstrb and size.
  - The next state is RD_A for a read or WR_AW for a write.
- Issue latency: AR/AW valid asserts the cycle after acceptance.
- RD_A:
  - arvalid = 1, driven from the latched registers.
  - Move to RD_D on arready.
- RD_D:
  - rready = 1.
  - On rvalid, pulse rsp_valid[idx] for exactly one cycle, the same cycle as the handshake.
  - rsp_rdata = rdata, rsp_err = |rresp.
  - Move to IDLE.
- WR_AW:
  - awvalid and wvalid both assert on entry.
  - Each drops independently after its own handshake; an aw_done/w_done flag tracks each channel.
  - Move to WR_B in the cycle where both handshakes are complete, including when both complete in the same cycle or W completes before AW.
  - wlast = wvalid.
- WR_B:
  - bready = 1.
  - On bvalid, pulse rsp_valid[idx], rsp_err = |bresp, rsp_rdata = 0.
  - Move to IDLE.
- Fairness:
  - On each completion, rr_ptr ← (idx+1) mod N.
  - With both clients requesting continuously, grants strictly alternate.
- AXI rules:
  - A valid, once asserted, is held with address and data stable until its handshake.
  - A ready or valid input arriving outside its state is ignored.
  - A requester may deassert req_valid before acceptance without effect.
- Back-to-back: a new request can be accepted in the cycle after rsp_valid, which is the IDLE cycle. Minimum read turnaround is 3 cycles: accept, AR, R.
- Alignment: addresses are not modified and read data is not lane-shifted; the requester extracts bytes.
- Reset mid-transaction:
  - Return to IDLE immediately and emit no rsp_valid.
  - The downstream slave is reset by the same reset.
- Out-of-range index: with no req_valid bits set, remain in IDLE and all req_ready = 0.

Test Plan:
- Single read: client 0 reads 0x8000_0000, with arready delayed 2 cycles and R returning 0x00000413 with OKAY. Expect:
  - req_ready[0] in cycle 0 and arvalid in cycles 1–3.
  - rsp_valid[0] for one cycle with rsp_rdata = 0x00000413 and rsp_err = 0.
- Write with W before AW: client 1 writes 0xDEADBEEF to 0x8000_0104 with wstrb = 0xF, wready = 1 immediately, awready after 3 cycles, then bresp = SLVERR. Expect:
  - wvalid for 1 cycle and awvalid for 4 cycles.
  - rsp_valid[1] with rsp_err = 1.
- Contention: both clients hold req_valid for 4 transactions with zero-wait slave. Expect grant order 0, 1, 0, 1, and no rsp_valid pulse to the non-owner.
- Simultaneous AW/W handshake: awready = wready = 1 on the first cycle. Expect WR_B on the next cycle, with awvalid and wvalid each high for exactly one cycle.
- Reset during RD_D: assert reset while rready = 1. Expect:
  - No rsp_valid.
  - All outputs 0 the next cycle.
  - The first post-reset grant goes to client 0.
- Stability: hold arready = 0 for 10 cycles while client 1 changes req_addr. Expect araddr unchanged and req_ready = 0 throughout.
